// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared widths, arbiter FSM state type and constant helpers
//               describing the Hamming(21,16) bit layout (position p = bit p-1,
//               check bits at power-of-two positions).
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int CW_W   = 21;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } arb_state_t;

    // Codeword bit index that carries data bit d (d-th non-power-of-two position).
    function automatic int data_pos(input int d);
        int cnt;
        cnt      = 0;
        data_pos = 0;
        for (int p = 1; p <= CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) data_pos = p - 1;
                cnt++;
            end
        end
    endfunction

    // Codeword bits whose 1-based position has bit b set; XOR over them gives syndrome bit b.
    function automatic logic [CW_W-1:0] syn_mask(input int b);
        syn_mask = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (((p >> b) & 1) != 0) syn_mask = syn_mask | (CW_W'(1) << (p - 1));
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_21_16_decoder_peres.sv
`default_nettype none
// ============================================================================
// Module      : hamming_21_16_decoder_peres
// Description : Single-error-correcting Hamming(21,16) decoder. Computes the
//               5-bit syndrome, flips the addressed bit and extracts the data
//               bits. Garbage outputs (received check bits) exist only to keep
//               the reversible-logic structure and are normally unconnected.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_21_16_decoder_peres
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   codeword,
    output logic [DATA_W-1:0] data_out,
    output logic              error_detected,
    output logic              error_corrected,
    output logic [4:0]        garbage
);

    logic [4:0]      w_syn;
    logic [CW_W-1:0] w_flip;
    logic [CW_W-1:0] w_fixed;

    for (genvar b = 0; b < 5; b++) begin : g_syn
        assign w_syn[b] = ^(codeword & syn_mask(b));
    end

    // A syndrome of 22..31 matches no position, so nothing is flipped.
    for (genvar i = 0; i < CW_W; i++) begin : g_flip
        assign w_flip[i] = (w_syn == 5'(i + 1));
    end

    assign w_fixed = codeword ^ w_flip;

    for (genvar d = 0; d < DATA_W; d++) begin : g_data
        localparam int P = data_pos(d);
        assign data_out[d] = w_fixed[P];
    end

    assign error_detected  = |w_syn;
    assign error_corrected = error_detected;
    assign garbage         = {codeword[15], codeword[7], codeword[3], codeword[1], codeword[0]};

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches upward from
//               last_grant+1 with wrap-around; returns one-hot grant and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    // First requester after last_grant wins; grant stays zero with no request.
    always_comb begin
        int   j;
        logic found;
        j       = 0;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_grant_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hamming_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decode_arbiter
// Description : Round-robin shares one Hamming(21,16) decoder between NUM_REQ
//               valid/ready requesters; returns corrected data, error flags
//               and requester ID on a single response port. Three-cycle
//               IDLE -> DECODE -> HOLD sequence per codeword.
//               Optional macro HAMMING_ARB_ERRCNT_EN adds a saturating error
//               counter (err_count / err_count_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_decode_arbiter
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef HAMMING_ARB_ERRCNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*CW_W-1:0] req_codeword,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_err_detected,
    output logic                    rsp_err_corrected
`ifdef HAMMING_ARB_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]        err_count,
    input  logic                    err_count_clr
`endif
);

    arb_state_t          state_q, state_d;
    logic [CW_W-1:0]     cw_q;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     last_grant_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_det_q;
    logic                rsp_cor_q;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic [CW_W-1:0]     w_req_cw;
    logic                w_accept;
    logic                w_decode;
    logic                w_rsp_hs;
    logic [DATA_W-1:0]   w_dec_data;
    logic                w_dec_det;
    logic                w_dec_cor;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant),
        .idx_o        (w_idx)
    );

    assign w_req_cw = req_codeword[int'(w_idx)*CW_W +: CW_W];

    hamming_21_16_decoder_peres u_decoder (
        .codeword        (cw_q),
        .data_out        (w_dec_data),
        .error_detected  (w_dec_det),
        .error_corrected (w_dec_cor),
        .garbage         ()
    );

    // State register; reset drops any in-flight codeword.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus accept/decode/handshake strobes; req_ready only ever in IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        w_accept  = 1'b0;
        w_decode  = 1'b0;
        w_rsp_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = w_grant;
                    w_accept  = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                w_decode = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (rsp_valid_q && rsp_ready) begin
                    w_rsp_hs = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted codeword, then register the decoder result for the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cw_q         <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_det_q    <= 1'b0;
            rsp_cor_q    <= 1'b0;
        end else begin
            if (w_accept) begin
                cw_q         <= w_req_cw;
                id_q         <= w_idx;
                last_grant_q <= w_idx;
            end
            if (w_decode) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= w_dec_data;
                rsp_id_q    <= id_q;
                rsp_det_q   <= w_dec_det;
                rsp_cor_q   <= w_dec_cor;
            end
            if (w_rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_id            = rsp_id_q;
    assign rsp_err_detected  = rsp_det_q;
    assign rsp_err_corrected = rsp_cor_q;

`ifdef HAMMING_ARB_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Saturating count of erroneous responses; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_count_clr) begin
            err_cnt_q <= '0;
        end else if (w_rsp_hs && rsp_det_q && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_decode_arbiter.sv
`timescale 1ns/1ps
module tb_hamming_decode_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*21-1:0] req_codeword;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_err_detected;
    logic            rsp_err_corrected;
`ifdef HAMMING_ARB_ERRCNT_EN
    logic [1:0]      err_count;
    logic            err_count_clr;
`endif

    always #5 clk = ~clk;

    hamming_decode_arbiter #(
        .NUM_REQ (N)
`ifdef HAMMING_ARB_ERRCNT_EN
        , .CNT_W (2)
`endif
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_codeword      (req_codeword),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_id            (rsp_id),
        .rsp_err_detected  (rsp_err_detected),
        .rsp_err_corrected (rsp_err_corrected)
`ifdef HAMMING_ARB_ERRCNT_EN
        , .err_count       (err_count)
        , .err_count_clr   (err_count_clr)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: data in non-power-of-two positions, even parity at 2^b.
    function automatic logic [20:0] encode(input logic [15:0] d);
        logic [20:0] cw;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 5; b++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= 21; p++)
                if (((p >> b) & 1) != 0 && (p & (p - 1)) != 0) par ^= cw[p-1];
            cw[(1 << b) - 1] = par;
        end
        return cw;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int r, input logic [20:0] cw);
        req_valid[r]            = 1'b1;
        req_codeword[r*21 +: 21] = cw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
`ifdef HAMMING_ARB_ERRCNT_EN
        err_count_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the caller at negedge+1 of the cycle in which req_ready[r] is high.
    task automatic wait_ready(input int r, input string nm, output bit ok);
        int n;
        n = 0;
        #1;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = req_ready[r];
        if (!ok) check({nm, " accept timeout"}, {31'd0, req_ready[r]}, 32'd1);
    endtask

    task automatic transact(input int r, input logic [20:0] cw, input logic [15:0] ed,
                            input logic edet, input string nm);
        bit ok;
        @(negedge clk);
        set_req(r, cw);
        wait_ready(r, nm, ok);
        if (!ok) begin
            req_valid[r] = 1'b0;
            return;
        end
        check({nm, " ready onehot"}, req_ready, 32'(1) << r);
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1 check({nm, " rsp_valid at t+1"}, rsp_valid, 0);
        @(negedge clk);
        #1 check({nm, " rsp_valid at t+2"}, rsp_valid, 1);
        check({nm, " data"}, rsp_data, ed);
        check({nm, " id"}, rsp_id, r);
        check({nm, " det"}, rsp_err_detected, edet);
        check({nm, " cor"}, rsp_err_corrected, edet);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        int          r;
        logic [20:0] cw;
        logic [15:0] d;
        logic        det;
    } vec_t;

    vec_t tv[7];

    typedef struct {
        int          id;
        logic [15:0] d;
        logic        det;
    } exp_t;

    initial begin
        bit          ok;
        exp_t        q[$];
        exp_t        e;
        logic [15:0] cur_d[N];
        logic        cur_e[N];
        int          m_last, exp_g, drop;
        bit          m_busy;

        rst_n        = 1'b0;
        req_valid    = '0;
        req_codeword = '0;
        rsp_ready    = 1'b0;
`ifdef HAMMING_ARB_ERRCNT_EN
        err_count_clr = 1'b0;
`endif

        tv[0] = '{0, 21'h000000, 16'h0000, 1'b0};
        tv[1] = '{2, 21'h000004, 16'h0000, 1'b1};
        tv[2] = '{1, 21'h000001, 16'h0000, 1'b1};
        tv[3] = '{3, encode(16'hA5C3), 16'hA5C3, 1'b0};
        tv[4] = '{1, encode(16'h1234) ^ (21'h1 << 20), 16'h1234, 1'b1};
        tv[5] = '{0, encode(16'hFFFF) ^ (21'h1 << 15), 16'hFFFF, 1'b1};
        tv[6] = '{2, encode(16'h8001) ^ (21'h1 << 9), 16'h8001, 1'b1};

        // Reset values
        do_reset();
        #1;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_det", rsp_err_detected, 0);
        check("reset rsp_cor", rsp_err_corrected, 0);
        check("reset req_ready idle", req_ready, 0);
`ifdef HAMMING_ARB_ERRCNT_EN
        check("reset err_count", err_count, 0);
`endif

        // Table-driven single transactions
        for (int i = 0; i < 7; i++)
            transact(tv[i].r, tv[i].cw, tv[i].d, tv[i].det, $sformatf("vec%0d", i));

        // Fairness: all four valid from reset, then 0 and 2 re-request
        begin
            int          order[5];
            int          gi, ri;
            logic [N-1:0] dmask;
            bit          rereq;
            order = '{0, 1, 2, 3, 0};
            gi = 0; ri = 0; dmask = '0; rereq = 0;
            do_reset();
            for (int i = 0; i < N; i++) set_req(i, encode(16'h1000 + 16'(i)));
            rsp_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && ri < 5; cyc++) begin
                if (cyc != 0) @(negedge clk);
                req_valid = req_valid & ~dmask;
                dmask = '0;
                if (gi == 4 && !rereq) begin
                    set_req(0, encode(16'h1000));
                    set_req(2, encode(16'h1002));
                    rereq = 1;
                end
                #1;
                if (req_ready != 0) begin
                    if (gi < 5) check($sformatf("fair grant%0d", gi), req_ready, 32'(1) << order[gi]);
                    dmask = req_ready;
                    gi++;
                end
                if (rsp_valid) begin
                    check($sformatf("fair rsp id%0d", ri), rsp_id, order[ri]);
                    check($sformatf("fair rsp data%0d", ri), rsp_data, 16'h1000 + 16'(order[ri]));
                    ri++;
                end
            end
            check("fair completed responses", ri, 5);
        end

        // Backpressure: response held stable, no accepts while in HOLD
        do_reset();
        @(negedge clk);
        set_req(1, encode(16'hBEEF) ^ (21'h1 << 5));
        wait_ready(1, "bp", ok);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(0, encode(16'h0F0F));
        set_req(2, encode(16'h2222));
        set_req(3, encode(16'h3333));
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp valid c%0d", c), rsp_valid, 1);
            check($sformatf("bp data c%0d", c), rsp_data, 16'hBEEF);
            check($sformatf("bp id c%0d", c), rsp_id, 1);
            check($sformatf("bp det c%0d", c), rsp_err_detected, 1);
            check($sformatf("bp no ready c%0d", c), req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 check("bp next grant after 1", req_ready, 32'b0100);

        // Reset while in DECODE drops the word
        do_reset();
        @(negedge clk);
        set_req(3, encode(16'h5A5A));
        wait_ready(3, "rst", ok);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("rst no rsp c%0d", c), rsp_valid, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, encode(16'h0));
        #1 check("rst last_grant restart", req_ready, 32'b0001);
        do_reset();

        // Randomized traffic against a transaction-level model
        m_last = N - 1; m_busy = 0; drop = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (drop >= 0) req_valid[drop] = 1'b0;
            drop = -1;
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(3) == 0) begin
                    logic [20:0] cw;
                    cur_d[r] = 16'($urandom);
                    cur_e[r] = 1'($urandom_range(1));
                    cw = encode(cur_d[r]);
                    if (cur_e[r]) cw = cw ^ (21'h1 << $urandom_range(20));
                    set_req(r, cw);
                end
            end
            rsp_ready = 1'($urandom_range(1));
            #1;
            exp_g = (!m_busy && req_valid != 0) ? rr_pick(req_valid, m_last) : -1;
            check("rand req_ready", req_ready, (exp_g < 0) ? 32'd0 : (32'(1) << exp_g));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("rand rsp without request", rsp_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("rand rsp id", rsp_id, e.id);
                    check("rand rsp data", rsp_data, e.d);
                    check("rand rsp det", rsp_err_detected, e.det);
                    check("rand rsp cor", rsp_err_corrected, e.det);
                end
                m_busy = 0;
            end
            if (exp_g >= 0) begin
                q.push_back('{exp_g, cur_d[exp_g], cur_e[exp_g]});
                m_last = exp_g;
                m_busy = 1;
                drop   = exp_g;
            end
        end

`ifdef HAMMING_ARB_ERRCNT_EN
        // Saturating error counter and clear priority
        do_reset();
        for (int i = 0; i < 5; i++) begin
            transact(i % N, 21'h000004, 16'h0000, 1'b1, $sformatf("cnt%0d", i));
            #1 check($sformatf("err_count after %0d", i + 1), err_count, (i < 3) ? i + 1 : 3);
        end
        @(negedge clk);
        set_req(0, 21'h000004);
        wait_ready(0, "clr", ok);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rsp_ready     = 1'b1;
        err_count_clr = 1'b1;
        @(negedge clk);
        rsp_ready     = 1'b0;
        err_count_clr = 1'b0;
        #1 check("err_count clear wins", err_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_decode_arbiter.md
# hamming_decode_arbiter

Shares a single `hamming_21_16_decoder_peres` datapath between `NUM_REQ` requesters. Each requester presents a 21-bit Hamming codeword over a valid/ready handshake. The block grants requesters round-robin, registers the granted codeword into the decoder, and returns the corrected 16-bit data, error flags and requester ID on a single valid/ready response port. It sits between the memory/link read-back ports and the consumer side of the ECC subsystem.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response requester ID.
- `CNT_W`, default 16: width of the error counter (only with `HAMMING_ARB_ERRCNT_EN`).

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  `NUM_REQ`: per-requester codeword valid.
- `req_codeword`  in  `NUM_REQ*21`: requester i occupies bits [21*i+20 : 21*i].
- `req_ready`  out  `NUM_REQ`: one-hot accept strobe.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_data`  out  16: corrected data.
- `rsp_id`  out  `ID_W`: index of the granted requester.
- `rsp_err_detected`  out  1: syndrome was non-zero.
- `rsp_err_corrected`  out  1: correction was applied (equals `rsp_err_detected`).
- `err_count`  out  `CNT_W`: saturating error count (`HAMMING_ARB_ERRCNT_EN` only).
- `err_count_clr`  in  1: synchronous counter clear (`HAMMING_ARB_ERRCNT_EN` only).

## Operation
- FSM states: IDLE, DECODE, HOLD.
- IDLE, when any `req_valid` is high:
  - grant the first valid requester searching upward, with wrap-around, from `last_grant+1`;
  - `req_ready[g]=1` combinationally in this cycle, which is the accept;
  - capture the codeword into `cw_q`, `g` into `id_q` and `g` into `last_grant`;
  - go to DECODE.
- DECODE:
  - the decoder is driven from `cw_q`;
  - register `data_out`, `error_detected` and `error_corrected` into the response registers;
  - set `rsp_valid=1`; go to HOLD.
- HOLD:
  - response registers are held stable;
  - when `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- `req_ready` is all-zero outside IDLE, and all-zero in IDLE when no requester is valid. At most one bit is ever set.
- Requesters must not gate `req_valid` on `req_ready`. Once asserted, `req_valid` and the codeword are held until accepted.
- Decoder garbage outputs are left unconnected.

## Timing
- Reset values:
  - state: IDLE.
  - `rsp_valid`: 0.
  - `rsp_data`: 0.
  - `rsp_id`: 0.
  - `rsp_err_detected`, `rsp_err_corrected`: 0.
  - `last_grant`: `NUM_REQ-1`, so requester 0 wins first.
  - `err_count`: 0.
- Latency: accept at cycle t gives `rsp_valid` at t+2.
- Peak throughput: one codeword per 3 cycles when `rsp_ready` is held at 1.
- Backpressure: with `rsp_ready=0` the block stays in HOLD indefinitely, holds all `rsp_*` stable, and accepts no request.
- Simultaneous requests: strict round-robin; no requester waits more than `NUM_REQ-1` grants.
- Reset mid-operation (DECODE or HOLD): the in-flight codeword is dropped with no response. Next cycle the block is in IDLE with reset values.

## Configuration
- Macro: `HAMMING_ARB_ERRCNT_EN`.
- Defined:
  - `err_count` increments by 1 on each response handshake with `rsp_err_detected=1`;
  - it saturates at all-ones;
  - `err_count_clr` clears it, and clear wins over a same-cycle increment.
- Undefined: the `err_count` and `err_count_clr` ports and the counter logic are absent.

## Structure
- Shared package `hamming_pkg` holds:
  - `CW_W=21` and `DATA_W=16`;
  - the FSM state enum `arb_state_t` {IDLE, DECODE, HOLD}.
- Sub-module `rr_arbiter`:
  - inputs: the request vector and `last_grant`;
  - outputs: a one-hot grant and an encoded index;
  - purely combinational.
- One `hamming_21_16_decoder_peres` instance.

## Test plan
- Clean word: requester 0 sends 21'h000000 → `rsp_data`=16'h0000, `rsp_id`=0, `rsp_err_detected`=0, `rsp_valid` two cycles after accept.
- Data-bit error: requester 2 sends 21'h000004 (bit 2 flipped) → `rsp_data`=16'h0000, `rsp_id`=2, `rsp_err_detected`=`rsp_err_corrected`=1.
- Parity-bit error: 21'h000001 → `rsp_data`=16'h0000, `rsp_err_detected`=1.
- Fairness: all four requesters valid from reset → grant order 0,1,2,3, then 0 again when requester 0 re-requests; `req_ready` is one-hot every accept.
- Backpressure and reset:
  - hold `rsp_ready=0` for 5 cycles in HOLD → `rsp_*` stable and no `req_ready` pulse;
  - pulse `rst_n=0` while in DECODE → `rsp_valid` stays 0 and no response is ever issued for that word.
- Counter (`HAMMING_ARB_ERRCNT_EN`, `CNT_W=2`):
  - five erroneous responses → `err_count`=3 (saturated);
  - `err_count_clr` in the same cycle as an erroneous handshake → 0.
